// File: rtl/dff_counter_ctrl.sv
// dff_counter_ctrl: run-control sequencer for the flip-flop counter datapath.
// Divides clk down to a count-enable tick and steps an up/down count between
// 0 and a programmable limit, with start/stop/pause, preload, terminal
// detection and optional auto-reload.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start/stop/pause  run control (priority stop > start > pause > load)
//   load, load_val    preload count (IDLE/DONE only)
//   limit             terminal value (up) / reload value (down)
//   div               prescale, one step every div+1 cycles
//   dir               1 = up, 0 = down
//   auto_reload       1 = wrap at terminal, 0 = stop in DONE
//   count             current count
//   tick              one-cycle pulse on each step
//   busy              high in RUN or PAUSE
//   done              high in DONE
//   wrap              one-cycle pulse on auto-reload
module dff_counter_ctrl #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [PSC_W-1:0] div,
    input  logic             dir,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   count_n;
    logic [PSC_W-1:0]   psc, psc_n;
    logic               tick_n, wrap_n, latch_cfg;

    // configuration captured on entry to RUN; inputs are ignored afterwards
    logic [WIDTH-1:0]   limit_r;
    logic [PSC_W-1:0]   div_r;
    logic               dir_r, ar_r;

    logic               term;

    // compare happens before the +/-1, so the count can never overflow
    assign term = dir_r ? (count >= limit_r) : (count == '0);

    always_comb begin
        state_n   = state;
        count_n   = count;
        psc_n     = psc;
        tick_n    = 1'b0;
        wrap_n    = 1'b0;
        latch_cfg = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    state_n   = RUN;
                    latch_cfg = 1'b1;
                    psc_n     = '0;
                    // restarting from DONE reloads using the freshly latched config
                    if (state == DONE)
                        count_n = dir ? '0 : limit;
                end else if (load) begin
                    count_n = load_val;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (pause) begin
                    state_n = PAUSE;
                end else if (psc == div_r) begin
                    psc_n  = '0;
                    tick_n = 1'b1;
                    if (term) begin
                        if (ar_r) begin
                            count_n = dir_r ? '0 : limit_r;
                            wrap_n  = 1'b1;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        count_n = dir_r ? count + 1'b1 : count - 1'b1;
                    end
                end else begin
                    psc_n = psc + 1'b1;
                end
            end
            PAUSE: begin
                // psc and count hold; resume picks up the partial prescale
                if (stop)
                    state_n = IDLE;
                else if (!pause)
                    state_n = RUN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            psc     <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            limit_r <= '0;
            div_r   <= '0;
            dir_r   <= 1'b0;
            ar_r    <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            psc   <= psc_n;
            tick  <= tick_n;
            wrap  <= wrap_n;
            busy  <= (state_n == RUN) || (state_n == PAUSE);
            done  <= (state_n == DONE);
            if (latch_cfg) begin
                limit_r <= limit;
                div_r   <= div;
                dir_r   <= dir;
                ar_r    <= auto_reload;
            end
        end
    end

endmodule

// File: tb/tb_dff_counter_ctrl.sv
module tb_dff_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, load, dir, auto_reload;
    logic [7:0] load_val, limit, div;
    logic [7:0] count;
    logic       tick, busy, done, wrap;

    int checks = 0;
    int errors = 0;

    dff_counter_ctrl #(.WIDTH(8), .PSC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .load(load), .load_val(load_val), .limit(limit), .div(div),
        .dir(dir), .auto_reload(auto_reload),
        .count(count), .tick(tick), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Reference model: a mode plus a countdown of cycles left until the next step.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_mode = M_IDLE;
    int m_count = 0, m_left = 0;
    int c_limit = 0, c_div = 0;
    bit c_up = 0, c_ar = 0;
    bit m_tick = 0, m_wrap = 0;

    task automatic model_edge();
        m_tick = 0;
        m_wrap = 0;
        if (rst) begin
            m_mode = M_IDLE; m_count = 0; m_left = 0;
            c_limit = 0; c_div = 0; c_up = 0; c_ar = 0;
            return;
        end
        if (m_mode == M_IDLE || m_mode == M_DONE) begin
            if (stop) m_mode = M_IDLE;
            else if (start) begin
                if (m_mode == M_DONE) m_count = dir ? 0 : int'(limit);
                c_limit = int'(limit); c_div = int'(div); c_up = dir; c_ar = auto_reload;
                m_left = c_div + 1;
                m_mode = M_RUN;
            end else if (load) m_count = int'(load_val);
        end else if (m_mode == M_RUN) begin
            if (stop) m_mode = M_IDLE;
            else if (pause) m_mode = M_PAUSE;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_left = c_div + 1;
                    m_tick = 1;
                    if ((c_up && m_count >= c_limit) || (!c_up && m_count == 0)) begin
                        if (c_ar) begin
                            m_count = c_up ? 0 : c_limit;
                            m_wrap  = 1;
                        end else m_mode = M_DONE;
                    end else m_count = c_up ? m_count + 1 : m_count - 1;
                end
            end
        end else begin
            if (stop) m_mode = M_IDLE;
            else if (!pause) m_mode = M_RUN;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("count", {24'd0, count}, m_count);
        chk("tick", {31'd0, tick}, {31'd0, m_tick});
        chk("wrap", {31'd0, wrap}, {31'd0, m_wrap});
        chk("busy", {31'd0, busy}, (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0);
        chk("done", {31'd0, done}, (m_mode == M_DONE) ? 1 : 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; pause = 0; load = 0;
        dir = 0; auto_reload = 0; load_val = 0; limit = 0; div = 0;

        // 1: up to limit 3, no reload, ends in DONE
        cycles(2);
        rst = 0; dir = 1; limit = 3; div = 0; auto_reload = 0; start = 1;
        cycle();
        start = 0;
        cycles(4);
        chk("t1_count", {24'd0, count}, 3);
        chk("t1_done", {31'd0, done}, 1);
        chk("t1_busy", {31'd0, busy}, 0);
        cycles(2);

        // 6a: restart from DONE reloads to 0
        start = 1;
        cycle();
        start = 0;
        chk("t6_reload", {24'd0, count}, 0);
        cycles(2);
        // 6b: reset mid-run clears everything
        rst = 1;
        cycle();
        chk("t6_rst_count", {24'd0, count}, 0);
        chk("t6_rst_busy", {31'd0, busy}, 0);
        rst = 0;

        // 2: div=2, step every third cycle
        dir = 1; limit = 5; div = 2; start = 1;
        cycle();
        start = 0;
        cycles(2);
        chk("t2_no_early_tick", {31'd0, tick}, 0);
        cycle();
        chk("t2_first_tick", {31'd0, tick}, 1);
        cycles(10);

        // 3: preload 4, count down with auto-reload to 6
        stop = 1; cycle(); stop = 0;
        load = 1; load_val = 4; cycle(); load = 0;
        dir = 0; auto_reload = 1; limit = 6; div = 0; start = 1;
        cycle();
        start = 0;
        cycles(4);
        chk("t3_zero", {24'd0, count}, 0);
        cycle();
        chk("t3_wrap", {31'd0, wrap}, 1);
        chk("t3_reload", {24'd0, count}, 6);
        chk("t3_busy", {31'd0, busy}, 1);
        cycles(3);

        // 4: pause mid-prescale
        stop = 1; cycle(); stop = 0;
        dir = 1; limit = 200; div = 3; auto_reload = 0; start = 1;
        cycle();
        start = 0;
        cycles(2);
        pause = 1; cycles(10);
        pause = 0; cycles(9);

        // 5: stop on a due step; load during RUN ignored
        stop = 1; cycle(); stop = 0;
        div = 0; start = 1; cycle(); start = 0;
        cycles(3);
        stop = 1; cycle(); stop = 0;
        chk("t5_no_tick", {31'd0, tick}, 0);
        start = 1; cycle(); start = 0;
        cycles(2);
        load = 1; load_val = 8'd99; cycle(); load = 0;
        cycles(2);

        // randomized soak
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            stop        = ($urandom_range(0, 29) == 0);
            start       = ($urandom_range(0, 7) == 0);
            load        = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            load_val    = 8'($urandom_range(0, 15));
            limit       = 8'($urandom_range(0, 12));
            div         = 8'($urandom_range(0, 3));
            dir         = 1'($urandom_range(0, 1));
            auto_reload = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
